// File: rtl/aes_serial_selftest.sv
// aes_serial_selftest
//   Self-test sequencer for one bit-serial AES encrypt/decrypt core pair.
//   A run does four steps:
//     1. Shift the plaintext and then the key into the encrypt core.
//     2. Read the ciphertext back from the encrypt core.
//     3. Shift that ciphertext and then the key into the decrypt core.
//     4. Read the recovered plaintext back from the decrypt core.
//   Both results are then compared against the port-supplied vectors.
//
// Optional build macro:
//   AES_ST_TIMEOUT_EN  enables a watchdog in E_WAIT/D_WAIT. After TIMEOUT
//                      wait cycles the run ends in DONE with o_timeout=1.
//                      Without the macro the WAIT states wait forever and
//                      o_timeout is tied to 0.
//
// Parameters: NK (key words, 4/6/8), TIMEOUT (wait-cycle limit).
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   i_start                        run request, sampled in IDLE/DONE only
//   i_plaintext, i_key             test vectors, bit 0 shifted first;
//                                  must stay stable while o_busy
//   i_expected_ct                  golden ciphertext
//   o_busy, o_done                 run in progress / run finished (level)
//   o_pass_enc, o_pass_dec         result flags, valid while o_done
//   o_timeout                      a WAIT state expired
//   o_enc_cs, o_enc_miso           encrypt core select and serial data out
//   i_enc_mosi, i_enc_finished     encrypt core serial data in and ready
//   o_dec_*, i_dec_*               same set for the decrypt core
//
// States:
//   IDLE   | waiting for start after reset
//   E_LOAD | shift plaintext then key into encrypt core
//   E_WAIT | wait for enc_finished
//   E_READ | capture 128 ciphertext bits
//   D_LOAD | shift captured ciphertext then key into decrypt core
//   D_WAIT | wait for dec_finished
//   D_READ | capture 128 recovered plaintext bits
//   CHECK  | compare results
//   DONE   | results held, start restarts
module aes_serial_selftest #(
    parameter int NK      = 6,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [127:0]        i_plaintext,
    input  logic [32*NK-1:0]    i_key,
    input  logic [127:0]        i_expected_ct,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass_enc,
    output logic                o_pass_dec,
    output logic                o_timeout,
    output logic                o_enc_cs,
    output logic                o_enc_miso,
    input  logic                i_enc_mosi,
    input  logic                i_enc_finished,
    output logic                o_dec_cs,
    output logic                o_dec_miso,
    input  logic                i_dec_mosi,
    input  logic                i_dec_finished
);
    localparam int         KEY_W     = 32 * NK;
    localparam logic [8:0] LOAD_LAST = 9'(128 + KEY_W - 1);
    localparam logic [8:0] READ_LAST = 9'd127;

    if (!(NK == 4 || NK == 6 || NK == 8) || TIMEOUT < 2) begin : g_bad_param
        $error("aes_serial_selftest: NK must be 4, 6 or 8 and TIMEOUT at least 2");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_E_LOAD, S_E_WAIT, S_E_READ,
        S_D_LOAD, S_D_WAIT, S_D_READ, S_CHECK, S_DONE
    } state_t;

    state_t       r_state;
    logic [8:0]   r_cnt;
    logic [127:0] r_ct;
    logic [127:0] r_pt;
    logic         r_busy;
    logic         r_done;
    logic         r_pass_enc;
    logic         r_pass_dec;
    logic         r_enc_cs;
    logic         r_enc_miso;
    logic         r_dec_cs;
    logic         r_dec_miso;

    // miso is registered, so each load cycle prepares the bit for the
    // following cycle: index r_cnt+1.
    logic [8:0]   w_nxt;
    logic [8:0]   w_kidx;
    logic [511:0] w_key_ext;
    logic         w_key_bit;
    logic         w_enc_bit;
    logic         w_dec_bit;

    assign w_nxt     = r_cnt + 9'd1;
    assign w_kidx    = w_nxt - 9'd128;
    assign w_key_ext = {{(512 - KEY_W){1'b0}}, i_key};
    assign w_key_bit = w_key_ext[w_kidx];
    assign w_enc_bit = (w_nxt < 9'd128) ? i_plaintext[w_nxt[6:0]] : w_key_bit;
    assign w_dec_bit = (w_nxt < 9'd128) ? r_ct[w_nxt[6:0]] : w_key_bit;

`ifdef AES_ST_TIMEOUT_EN
    localparam int              WT_W      = $clog2(TIMEOUT);
    localparam logic [WT_W-1:0] WAIT_LOAD = WT_W'(TIMEOUT - 1);

    logic [WT_W-1:0] r_wait;
    logic            r_timeout;
    logic            w_wait_tc;

    assign w_wait_tc = (r_wait == '0);
    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ct       <= '0;
            r_pt       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass_enc <= 1'b0;
            r_pass_dec <= 1'b0;
            r_enc_cs   <= 1'b0;
            r_enc_miso <= 1'b0;
            r_dec_cs   <= 1'b0;
            r_dec_miso <= 1'b0;
`ifdef AES_ST_TIMEOUT_EN
            r_wait     <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state    <= S_E_LOAD;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass_enc <= 1'b0;
                        r_pass_dec <= 1'b0;
                        r_enc_cs   <= 1'b1;
                        r_enc_miso <= i_plaintext[0];
`ifdef AES_ST_TIMEOUT_EN
                        r_timeout  <= 1'b0;
`endif
                    end
                end
                S_E_LOAD: begin
                    if (r_cnt == LOAD_LAST) begin
                        r_state    <= S_E_WAIT;
                        r_cnt      <= '0;
                        r_enc_cs   <= 1'b0;
                        r_enc_miso <= 1'b0;
`ifdef AES_ST_TIMEOUT_EN
                        r_wait     <= WAIT_LOAD;
`endif
                    end else begin
                        r_cnt      <= w_nxt;
                        r_enc_miso <= w_enc_bit;
                    end
                end
                S_E_WAIT: begin
                    if (i_enc_finished) begin
                        r_state  <= S_E_READ;
                        r_cnt    <= '0;
                        r_enc_cs <= 1'b1;
                    end
`ifdef AES_ST_TIMEOUT_EN
                    else if (w_wait_tc) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
`endif
                end
                S_E_READ: begin
                    r_ct[r_cnt[6:0]] <= i_enc_mosi;
                    if (r_cnt == READ_LAST) begin
                        r_state    <= S_D_LOAD;
                        r_cnt      <= '0;
                        r_enc_cs   <= 1'b0;
                        r_dec_cs   <= 1'b1;
                        r_dec_miso <= r_ct[0];
                    end else begin
                        r_cnt <= w_nxt;
                    end
                end
                S_D_LOAD: begin
                    if (r_cnt == LOAD_LAST) begin
                        r_state    <= S_D_WAIT;
                        r_cnt      <= '0;
                        r_dec_cs   <= 1'b0;
                        r_dec_miso <= 1'b0;
`ifdef AES_ST_TIMEOUT_EN
                        r_wait     <= WAIT_LOAD;
`endif
                    end else begin
                        r_cnt      <= w_nxt;
                        r_dec_miso <= w_dec_bit;
                    end
                end
                S_D_WAIT: begin
                    if (i_dec_finished) begin
                        r_state  <= S_D_READ;
                        r_cnt    <= '0;
                        r_dec_cs <= 1'b1;
                    end
`ifdef AES_ST_TIMEOUT_EN
                    else if (w_wait_tc) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
`endif
                end
                S_D_READ: begin
                    r_pt[r_cnt[6:0]] <= i_dec_mosi;
                    if (r_cnt == READ_LAST) begin
                        r_state  <= S_CHECK;
                        r_cnt    <= '0;
                        r_dec_cs <= 1'b0;
                    end else begin
                        r_cnt <= w_nxt;
                    end
                end
                S_CHECK: begin
                    r_state    <= S_DONE;
                    r_pass_enc <= (r_ct == i_expected_ct);
                    r_pass_dec <= (r_pt == i_plaintext);
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_pass_enc = r_pass_enc;
    assign o_pass_dec = r_pass_dec;
    assign o_enc_cs   = r_enc_cs;
    assign o_enc_miso = r_enc_miso;
    assign o_dec_cs   = r_dec_cs;
    assign o_dec_miso = r_dec_miso;

endmodule

// File: tb/tb_aes_serial_selftest.sv
// Testbench for aes_serial_selftest: three DUTs (NK = 4, 6, 8), each
// attached to behavioural serial cores that answer the published AES test
// vectors by table lookup.
module tb_aes_serial_selftest;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K4  = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
    localparam logic [255:0] K6  = {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
    localparam logic [255:0] K8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam int MOCK_DLY  = 5;
    localparam int TW_EXP    = MOCK_DLY + 1;
    localparam int RUN_LIMIT = 3000;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] pt;
    logic [255:0] key_full;
    logic [2:0]   start_v;
    logic [2:0]   hold_v;
    logic [127:0] exp_v [3];
    logic [2:0]   busy_v, done_v, pe_v, pd_v, to_v, ecs_v, dcs_v, emiso_v, dmiso_v;
    int           overlap_cnt = 0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    function automatic logic [127:0] core_fn(input logic dec, input logic [127:0] d,
                                             input logic [255:0] k);
        logic [127:0] r;
        r = d ^ 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
        if (k == K4) r = dec ? ((d == CT4) ? PT : r) : ((d == PT) ? CT4 : r);
        if (k == K6) r = dec ? ((d == CT6) ? PT : r) : ((d == PT) ? CT6 : r);
        if (k == K8) r = dec ? ((d == CT8) ? PT : r) : ((d == PT) ? CT8 : r);
        return r;
    endfunction

    function automatic int lat_exp(input int kw);
        return 2 * (128 + kw) + 2 * 128 + 2 * TW_EXP + 3;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int KW = (g == 0) ? 128 : (g == 1) ? 192 : 256;
        logic [1:0] w_cs, w_miso, w_mosi, w_fin;
        logic       w_busy, w_done, w_pe, w_pd, w_to;

        aes_serial_selftest #(.NK(KW / 32), .TIMEOUT(16)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .i_start        (start_v[g]),
            .i_plaintext    (pt),
            .i_key          (key_full[KW-1:0]),
            .i_expected_ct  (exp_v[g]),
            .o_busy         (w_busy),
            .o_done         (w_done),
            .o_pass_enc     (w_pe),
            .o_pass_dec     (w_pd),
            .o_timeout      (w_to),
            .o_enc_cs       (w_cs[0]),
            .o_enc_miso     (w_miso[0]),
            .i_enc_mosi     (w_mosi[0]),
            .i_enc_finished (w_fin[0]),
            .o_dec_cs       (w_cs[1]),
            .o_dec_miso     (w_miso[1]),
            .i_dec_mosi     (w_mosi[1]),
            .i_dec_finished (w_fin[1])
        );

        assign busy_v[g]  = w_busy;
        assign done_v[g]  = w_done;
        assign pe_v[g]    = w_pe;
        assign pd_v[g]    = w_pd;
        assign to_v[g]    = w_to;
        assign ecs_v[g]   = w_cs[0];
        assign dcs_v[g]   = w_cs[1];
        assign emiso_v[g] = w_miso[0];
        assign dmiso_v[g] = w_miso[1];

        // c = 0 encrypt core, c = 1 decrypt core
        for (genvar c = 0; c < 2; c++) begin : g_core
            logic [127:0] m_data, m_res;
            logic [255:0] m_key;
            logic [8:0]   m_idx;
            logic [6:0]   m_ridx;
            logic [1:0]   m_mode;
            int           m_wc;
            logic         m_fin;

            assign w_mosi[c] = m_res[m_ridx];
            assign w_fin[c]  = m_fin;

            always @(posedge clk or posedge rst) begin
                if (rst) begin
                    m_mode <= 2'd0;
                    m_idx  <= '0;
                    m_ridx <= '0;
                    m_wc   <= 0;
                    m_fin  <= 1'b0;
                    m_res  <= '0;
                end else begin
                    case (m_mode)
                        2'd0: if (w_cs[c]) begin
                            if (m_idx == 9'd0) m_key <= '0;
                            if (m_idx < 9'd128) m_data[m_idx[6:0]] <= w_miso[c];
                            else m_key[m_idx[7:0] - 8'd128] <= w_miso[c];
                            if (m_idx == 9'(128 + KW - 1)) begin
                                m_mode <= 2'd1;
                                m_wc   <= MOCK_DLY;
                                m_idx  <= '0;
                            end else begin
                                m_idx <= m_idx + 9'd1;
                            end
                        end
                        2'd1: if (!(c == 0 && hold_v[g])) begin
                            if (m_wc == 1) begin
                                m_fin  <= 1'b1;
                                m_mode <= 2'd2;
                                m_ridx <= '0;
                                m_res  <= core_fn(c == 1, m_data, m_key);
                            end else begin
                                m_wc <= m_wc - 1;
                            end
                        end
                        default: if (w_cs[c]) begin
                            m_fin  <= 1'b0;
                            m_ridx <= m_ridx + 7'd1;
                            if (m_ridx == 7'd127) m_mode <= 2'd0;
                        end
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ((ecs_v & dcs_v) != 3'b000)) overlap_cnt++;
    end

    task automatic do_run(input int k, input logic [127:0] exp_ct, input int poke_at,
                          output int lat, output int load_len,
                          output logic b2, output logic d2, output logic pd2);
        int cnt;
        bit fell;
        cnt = 0; fell = 0; load_len = 0; b2 = 1'b0; d2 = 1'b0; pd2 = 1'b0;
        exp_v[k] = exp_ct;
        @(negedge clk);
        start_v[k] = 1'b1;
        lat = 1;
        while (lat < RUN_LIMIT) begin
            @(negedge clk);
            lat++;
            if (lat == 2) begin
                start_v[k] = 1'b0;
                b2  = busy_v[k];
                d2  = done_v[k];
                pd2 = pd_v[k];
            end
            if (poke_at != 0 && lat == poke_at)     start_v[k] = 1'b1;
            if (poke_at != 0 && lat == poke_at + 1) start_v[k] = 1'b0;
            if (!fell) begin
                if (ecs_v[k]) cnt++;
                else if (cnt > 0) begin
                    fell = 1;
                    load_len = cnt;
                end
            end
            if (done_v[k]) break;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({busy_v[g], done_v[g], pe_v[g], pd_v[g], to_v[g], ecs_v[g], dcs_v[g],
                 emiso_v[g], dmiso_v[g]} !== 9'b0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %b want 000000000", g,
                         {busy_v[g], done_v[g], pe_v[g], pd_v[g], to_v[g], ecs_v[g], dcs_v[g],
                          emiso_v[g], dmiso_v[g]});
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_v !== 3'b000) begin
            errors++;
            $display("FAIL idle_no_start_busy: got %b want 000", busy_v);
        end
    endtask

    task automatic test_nk4;
        int lat, ll;
        logic b2, d2, pd2;
        key_full = K4;
        do_run(0, CT4, 0, lat, ll, b2, d2, pd2);
        checks++;
        if ({done_v[0], pe_v[0], pd_v[0], to_v[0]} !== 4'b1110) begin
            errors++;
            $display("FAIL nk4_flags(done,pe,pd,to): got %b want 1110",
                     {done_v[0], pe_v[0], pd_v[0], to_v[0]});
        end
        checks++;
        if (lat !== lat_exp(128)) begin
            errors++;
            $display("FAIL nk4_latency: got %0d want %0d", lat, lat_exp(128));
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({busy_v[0], done_v[0]} !== 2'b01) begin
            errors++;
            $display("FAIL nk4_done_level(busy,done): got %b want 01", {busy_v[0], done_v[0]});
        end
    endtask

    task automatic test_nk6;
        int lat, ll;
        logic b2, d2, pd2;
        key_full = K6;
        do_run(1, CT6, 0, lat, ll, b2, d2, pd2);
        checks++;
        if ({done_v[1], pe_v[1], pd_v[1]} !== 3'b111) begin
            errors++;
            $display("FAIL nk6_flags(done,pe,pd): got %b want 111", {done_v[1], pe_v[1], pd_v[1]});
        end
        checks++;
        if (ll !== 320) begin
            errors++;
            $display("FAIL nk6_eload_cs_len: got %0d want 320", ll);
        end
        checks++;
        if (lat !== lat_exp(192)) begin
            errors++;
            $display("FAIL nk6_latency: got %0d want %0d", lat, lat_exp(192));
        end
    endtask

    task automatic test_nk8;
        int lat, ll;
        logic b2, d2, pd2;
        key_full = K8;
        do_run(2, CT8, 0, lat, ll, b2, d2, pd2);
        checks++;
        if ({done_v[2], pe_v[2], pd_v[2]} !== 3'b111) begin
            errors++;
            $display("FAIL nk8_flags(done,pe,pd): got %b want 111", {done_v[2], pe_v[2], pd_v[2]});
        end
        checks++;
        if (lat !== 1039) begin
            errors++;
            $display("FAIL nk8_latency: got %0d want 1039", lat);
        end
        checks++;
        if (ll !== 384) begin
            errors++;
            $display("FAIL nk8_eload_cs_len: got %0d want 384", ll);
        end
    endtask

    task automatic test_bad_ct;
        int lat, ll;
        logic b2, d2, pd2;
        key_full = K6;
        do_run(1, CT6 ^ 128'h1, 0, lat, ll, b2, d2, pd2);
        checks++;
        if ({done_v[1], pe_v[1], pd_v[1]} !== 3'b101) begin
            errors++;
            $display("FAIL bad_ct_flags(done,pe,pd): got %b want 101", {done_v[1], pe_v[1], pd_v[1]});
        end
    endtask

    task automatic test_back_to_back;
        int lat, ll;
        logic b2, d2, pd2;
        key_full = K6;
        do_run(1, CT6, 100, lat, ll, b2, d2, pd2);
        checks++;
        if ({b2, d2, pd2} !== 3'b100) begin
            errors++;
            $display("FAIL restart_clear(busy,done,pd): got %b want 100", {b2, d2, pd2});
        end
        checks++;
        if ({pe_v[1], pd_v[1]} !== 2'b11) begin
            errors++;
            $display("FAIL restart_pass(pe,pd): got %b want 11", {pe_v[1], pd_v[1]});
        end
        checks++;
        if (lat !== lat_exp(192)) begin
            errors++;
            $display("FAIL busy_start_ignored_latency: got %0d want %0d", lat, lat_exp(192));
        end
    endtask

    task automatic test_reset_mid;
        int n, lat, ll;
        logic b2, d2, pd2;
        key_full = K6;
        exp_v[1] = CT6;
        @(negedge clk); start_v[1] = 1'b1;
        @(negedge clk); start_v[1] = 1'b0;
        n = 0;
        while (!dcs_v[1] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dcs_v[1] !== 1'b1) begin
            errors++;
            $display("FAIL reach_d_load: got dec_cs=%b want 1", dcs_v[1]);
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (dcs_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_dec_cs: got %b want 0", dcs_v[1]);
        end
        checks++;
        if ({busy_v[1], done_v[1]} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_busy_done: got %b want 00", {busy_v[1], done_v[1]});
        end
        @(negedge clk);
        rst = 1'b0;
        do_run(1, CT6, 0, lat, ll, b2, d2, pd2);
        checks++;
        if ({done_v[1], pe_v[1], pd_v[1]} !== 3'b111) begin
            errors++;
            $display("FAIL after_reset_run(done,pe,pd): got %b want 111",
                     {done_v[1], pe_v[1], pd_v[1]});
        end
    endtask

    task automatic test_timeout;
        int n;
        key_full = K6;
        exp_v[1] = CT6;
        hold_v[1] = 1'b1;
        @(negedge clk); start_v[1] = 1'b1;
        @(negedge clk); start_v[1] = 1'b0;
        n = 0;
        while (!ecs_v[1] && n < 50) begin @(negedge clk); n++; end
        while (ecs_v[1] && n < 1000) begin @(negedge clk); n++; end
`ifdef AES_ST_TIMEOUT_EN
        n = 1;
        while (n < 200) begin
            @(negedge clk);
            if (done_v[1]) break;
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL timeout_wait_cycles: got %0d want 16", n);
        end
        checks++;
        if ({busy_v[1], done_v[1], to_v[1], pe_v[1], pd_v[1]} !== 5'b01100) begin
            errors++;
            $display("FAIL timeout_flags(busy,done,to,pe,pd): got %b want 01100",
                     {busy_v[1], done_v[1], to_v[1], pe_v[1], pd_v[1]});
        end
`else
        repeat (300) @(negedge clk);
        checks++;
        if ({busy_v[1], done_v[1], to_v[1]} !== 3'b100) begin
            errors++;
            $display("FAIL no_timeout_hang(busy,done,to): got %b want 100",
                     {busy_v[1], done_v[1], to_v[1]});
        end
`endif
        hold_v[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cs_exclusive;
        checks++;
        if (overlap_cnt !== 0) begin
            errors++;
            $display("FAIL cs_exclusive: got %0d overlap cycles want 0", overlap_cnt);
        end
    endtask

    initial begin
        pt       = PT;
        key_full = K6;
        start_v  = 3'b000;
        hold_v   = 3'b000;
        for (int g = 0; g < 3; g++) exp_v[g] = '0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        test_reset();
        test_nk4();
        test_nk6();
        test_nk8();
        test_bad_ct();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_cs_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
